// File: rtl/mem_arbiter_pkg.sv
// Shared types for the cache-to-memory arbiter: RAM handshake state, word type,
// arbiter FSM states and the grant-owner tag used for round-robin fairness.
package mem_arbiter_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    MA_IDLE   = 2'd0,
    MA_IFETCH = 2'd1,
    MA_DREAD  = 2'd2,
    MA_DWRITE = 2'd3
  } mem_arb_state_t;

  typedef enum logic {
    ICACHE = 1'b0,
    DCACHE = 1'b1
  } arb_owner_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the icache, dcache and RAM-side signals seen by the arbiter.
// slave is the arbiter's view; master is the caches-plus-RAM environment.
interface mem_arbiter_if;
  import mem_arbiter_pkg::*;

  logic      iREN;
  word_t     iaddr;
  logic      iwait;
  word_t     iload;

  logic      dREN;
  logic      dWEN;
  word_t     daddr;
  word_t     dstore;
  logic      dwait;
  word_t     dload;

  logic      ramREN;
  logic      ramWEN;
  word_t     ramaddr;
  word_t     ramstore;
  word_t     ramload;
  ramstate_t ramstate;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );

endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates icache fetches and dcache reads/writes onto a single-ported RAM.
// One grant at a time; every transaction passes through MA_IDLE for arbitration.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter logic RR_EN = 1'b1
) (
  input  logic          CLK,
  input  logic          nRST,
  mem_arbiter_if.slave  bus
);

  mem_arb_state_t state_q, state_d;
  arb_owner_t     last_grant_q, last_grant_d;
  mem_arb_state_t arb_next;
  logic           data_req;
  mem_arb_state_t data_state;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q      <= MA_IDLE;
      last_grant_q <= ICACHE;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Writes beat reads on the data side; round-robin only matters when both caches ask.
  always_comb begin
    data_req   = bus.dWEN | bus.dREN;
    data_state = bus.dWEN ? MA_DWRITE : MA_DREAD;
    arb_next   = MA_IDLE;
    if (data_req && bus.iREN) begin
      if (RR_EN && (last_grant_q == DCACHE)) arb_next = MA_IFETCH;
      else                                   arb_next = data_state;
    end else if (data_req) begin
      arb_next = data_state;
    end else if (bus.iREN) begin
      arb_next = MA_IFETCH;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    bus.iwait    = 1'b1;
    bus.dwait    = 1'b1;
    bus.iload    = '0;
    bus.dload    = '0;
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;

    case (state_q)
      MA_IDLE: state_d = arb_next;

      MA_IFETCH: begin
        bus.ramREN  = 1'b1;
        bus.ramaddr = bus.iaddr;
        // A withdrawn request abandons the access without a wait pulse, even on ACCESS.
        if (!bus.iREN) begin
          state_d = MA_IDLE;
        end else if (bus.ramstate == ACCESS) begin
          bus.iwait    = 1'b0;
          bus.iload    = bus.ramload;
          state_d      = MA_IDLE;
          last_grant_d = ICACHE;
        end
      end

      MA_DREAD: begin
        bus.ramREN  = 1'b1;
        bus.ramaddr = bus.daddr;
        if (!bus.dREN) begin
          state_d = MA_IDLE;
        end else if (bus.ramstate == ACCESS) begin
          bus.dwait    = 1'b0;
          bus.dload    = bus.ramload;
          state_d      = MA_IDLE;
          last_grant_d = DCACHE;
        end
      end

      MA_DWRITE: begin
        bus.ramWEN   = 1'b1;
        bus.ramaddr  = bus.daddr;
        bus.ramstore = bus.dstore;
        if (!bus.dWEN) begin
          state_d = MA_IDLE;
        end else if (bus.ramstate == ACCESS) begin
          bus.dwait    = 1'b0;
          state_d      = MA_IDLE;
          last_grant_d = DCACHE;
        end
      end

      default: state_d = MA_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: the bench plays both caches and the RAM,
// driving inputs after each falling edge and checking outputs 1 ns later.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic CLK;
  logic nRST;
  int   n_assert;
  int   n_fail;

  mem_arbiter_if bus ();

  mem_arbiter #(.RR_EN(1'b1)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic idle_inputs();
    bus.iREN     = 1'b0;
    bus.dREN     = 1'b0;
    bus.dWEN     = 1'b0;
    bus.iaddr    = '0;
    bus.daddr    = '0;
    bus.dstore   = '0;
    bus.ramload  = '0;
    bus.ramstate = FREE;
  endtask

  task automatic pulse_reset();
    @(negedge CLK);
    nRST = 1'b0;
    #1;
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  // ctl vectors below are {ramREN, ramWEN, iwait, dwait}
  task automatic test_reset();
    logic [3:0] ctl;
    @(negedge CLK);
    #1;
    ctl = {bus.ramREN, bus.ramWEN, bus.iwait, bus.dwait};
    n_assert++;
    if (ctl !== 4'b0011) begin n_fail++; $display("FAIL reset_ctl: got %b want 0011", ctl); end
    n_assert++;
    if ({bus.ramaddr, bus.ramstore, bus.iload, bus.dload} !== 128'd0) begin
      n_fail++; $display("FAIL reset_data: addr=%h store=%h iload=%h dload=%h want all 0",
                         bus.ramaddr, bus.ramstore, bus.iload, bus.dload);
    end
    @(negedge CLK);
    nRST = 1'b1;
    bus.dREN = 1'b1; bus.daddr = 32'h0000_0500; bus.ramstate = BUSY;
    #1;
    ctl = {bus.ramREN, bus.ramWEN, bus.iwait, bus.dwait};
    n_assert++;
    if (ctl !== 4'b0011) begin n_fail++; $display("FAIL reset_arb_cycle: got %b want 0011", ctl); end
    @(negedge CLK);
    #1;
    ctl = {bus.ramREN, bus.ramWEN, bus.iwait, bus.dwait};
    n_assert++;
    if (ctl !== 4'b1011 || bus.ramaddr !== 32'h0000_0500) begin
      n_fail++; $display("FAIL reset_dread_grant: ctl=%b addr=%h want 1011 00000500", ctl, bus.ramaddr);
    end
    #1 nRST = 1'b0;
    #1;
    ctl = {bus.ramREN, bus.ramWEN, bus.iwait, bus.dwait};
    n_assert++;
    if (ctl !== 4'b0011 || bus.ramaddr !== 32'd0) begin
      n_fail++; $display("FAIL reset_async_ctl: ctl=%b addr=%h want 0011 00000000", ctl, bus.ramaddr);
    end
    n_assert++;
    if (dut.state_q !== MA_IDLE) begin
      n_fail++; $display("FAIL reset_async_state: got %0d want %0d", dut.state_q, MA_IDLE);
    end
    @(negedge CLK);
    idle_inputs();
    nRST = 1'b1;
  endtask

  task automatic test_ifetch();
    logic [3:0]  exp_ctl  [0:4] = '{4'b0011, 4'b1011, 4'b1011, 4'b1001, 4'b0011};
    logic        ren      [0:4] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    ramstate_t   rs       [0:4] = '{BUSY, BUSY, BUSY, ACCESS, FREE};
    logic [31:0] exp_addr [0:4] = '{32'h0, 32'h40, 32'h40, 32'h40, 32'h0};
    logic [31:0] exp_ild  [0:4] = '{32'h0, 32'h0, 32'h0, 32'h2401_0005, 32'h0};
    logic [3:0]  ctl;
    for (int c = 0; c < 5; c++) begin
      @(negedge CLK);
      bus.iREN = ren[c]; bus.iaddr = 32'h0000_0040;
      bus.ramstate = rs[c]; bus.ramload = 32'h2401_0005;
      #1;
      ctl = {bus.ramREN, bus.ramWEN, bus.iwait, bus.dwait};
      n_assert++;
      if (ctl !== exp_ctl[c]) begin n_fail++; $display("FAIL ifetch_ctl c%0d: got %b want %b", c, ctl, exp_ctl[c]); end
      n_assert++;
      if (bus.ramaddr !== exp_addr[c]) begin n_fail++; $display("FAIL ifetch_addr c%0d: got %h want %h", c, bus.ramaddr, exp_addr[c]); end
      n_assert++;
      if (bus.iload !== exp_ild[c]) begin n_fail++; $display("FAIL ifetch_iload c%0d: got %h want %h", c, bus.iload, exp_ild[c]); end
    end
    idle_inputs();
  endtask

  task automatic test_contention();
    logic [3:0]  exp_ctl  [0:7] = '{4'b0011, 4'b1010, 4'b0011, 4'b1001, 4'b0011, 4'b1010, 4'b0011, 4'b1001};
    logic [31:0] exp_addr [0:7] = '{32'h0, 32'h200, 32'h0, 32'h40, 32'h0, 32'h200, 32'h0, 32'h40};
    logic        dsel     [0:7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic        isel     [0:7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [3:0]  ctl;
    pulse_reset();
    for (int c = 0; c < 8; c++) begin
      @(negedge CLK);
      bus.iREN = 1'b1; bus.iaddr = 32'h0000_0040;
      bus.dREN = 1'b1; bus.daddr = 32'h0000_0200;
      bus.ramstate = ACCESS; bus.ramload = 32'h1111_2222;
      #1;
      ctl = {bus.ramREN, bus.ramWEN, bus.iwait, bus.dwait};
      n_assert++;
      if (ctl !== exp_ctl[c]) begin n_fail++; $display("FAIL rr_ctl c%0d: got %b want %b", c, ctl, exp_ctl[c]); end
      n_assert++;
      if (bus.ramaddr !== exp_addr[c]) begin n_fail++; $display("FAIL rr_addr c%0d: got %h want %h", c, bus.ramaddr, exp_addr[c]); end
      n_assert++;
      if (bus.dload !== (dsel[c] ? 32'h1111_2222 : 32'h0) || bus.iload !== (isel[c] ? 32'h1111_2222 : 32'h0)) begin
        n_fail++; $display("FAIL rr_load c%0d: got iload=%h dload=%h", c, bus.iload, bus.dload);
      end
    end
    idle_inputs();
  endtask

  task automatic test_write_priority();
    logic [3:0]  exp_ctl  [0:3] = '{4'b0011, 4'b0111, 4'b0110, 4'b0011};
    logic        req      [0:3] = '{1'b1, 1'b1, 1'b1, 1'b0};
    ramstate_t   rs       [0:3] = '{BUSY, BUSY, ACCESS, FREE};
    logic [31:0] exp_addr [0:3] = '{32'h0, 32'h100, 32'h100, 32'h0};
    logic [31:0] exp_st   [0:3] = '{32'h0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0};
    logic [3:0]  ctl;
    for (int c = 0; c < 4; c++) begin
      @(negedge CLK);
      bus.dWEN = req[c]; bus.dREN = req[c];
      bus.daddr = 32'h0000_0100; bus.dstore = 32'hDEAD_BEEF;
      bus.ramstate = rs[c]; bus.ramload = 32'h5555_AAAA;
      #1;
      ctl = {bus.ramREN, bus.ramWEN, bus.iwait, bus.dwait};
      n_assert++;
      if (ctl !== exp_ctl[c]) begin n_fail++; $display("FAIL wr_ctl c%0d: got %b want %b", c, ctl, exp_ctl[c]); end
      n_assert++;
      if (bus.ramaddr !== exp_addr[c] || bus.ramstore !== exp_st[c]) begin
        n_fail++; $display("FAIL wr_bus c%0d: got addr=%h store=%h want %h %h", c, bus.ramaddr, bus.ramstore, exp_addr[c], exp_st[c]);
      end
      n_assert++;
      if (bus.dload !== 32'h0) begin n_fail++; $display("FAIL wr_dload c%0d: got %h want 0", c, bus.dload); end
    end
    idle_inputs();
  endtask

  task automatic test_error_retry();
    logic [3:0]  exp_ctl  [0:5] = '{4'b0011, 4'b1011, 4'b1011, 4'b1011, 4'b1010, 4'b0011};
    logic        req      [0:5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    ramstate_t   rs       [0:5] = '{ERROR, ERROR, ERROR, ERROR, ACCESS, FREE};
    logic [31:0] exp_addr [0:5] = '{32'h0, 32'h300, 32'h300, 32'h300, 32'h300, 32'h0};
    logic [31:0] exp_dld  [0:5] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'hCAFE_0001, 32'h0};
    logic [3:0]  ctl;
    for (int c = 0; c < 6; c++) begin
      @(negedge CLK);
      bus.dREN = req[c]; bus.daddr = 32'h0000_0300;
      bus.ramstate = rs[c]; bus.ramload = 32'hCAFE_0001;
      #1;
      ctl = {bus.ramREN, bus.ramWEN, bus.iwait, bus.dwait};
      n_assert++;
      if (ctl !== exp_ctl[c]) begin n_fail++; $display("FAIL err_ctl c%0d: got %b want %b", c, ctl, exp_ctl[c]); end
      n_assert++;
      if (bus.ramaddr !== exp_addr[c]) begin n_fail++; $display("FAIL err_addr c%0d: got %h want %h", c, bus.ramaddr, exp_addr[c]); end
      n_assert++;
      if (bus.dload !== exp_dld[c]) begin n_fail++; $display("FAIL err_dload c%0d: got %h want %h", c, bus.dload, exp_dld[c]); end
    end
    idle_inputs();
  endtask

  task automatic test_withdraw();
    logic [3:0]  exp_ctl  [0:5] = '{4'b0011, 4'b1011, 4'b1011, 4'b0011, 4'b1010, 4'b0011};
    logic        ireq     [0:5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic        dreq     [0:5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    ramstate_t   rs       [0:5] = '{BUSY, BUSY, BUSY, FREE, ACCESS, FREE};
    logic [31:0] exp_addr [0:5] = '{32'h0, 32'h80, 32'h80, 32'h0, 32'h400, 32'h0};
    logic [31:0] exp_dld  [0:5] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h7777_0003, 32'h0};
    logic [3:0]  ctl;
    for (int c = 0; c < 6; c++) begin
      @(negedge CLK);
      bus.iREN = ireq[c]; bus.iaddr = 32'h0000_0080;
      bus.dREN = dreq[c]; bus.daddr = 32'h0000_0400;
      bus.ramstate = rs[c]; bus.ramload = 32'h7777_0003;
      #1;
      ctl = {bus.ramREN, bus.ramWEN, bus.iwait, bus.dwait};
      n_assert++;
      if (ctl !== exp_ctl[c]) begin n_fail++; $display("FAIL wd_ctl c%0d: got %b want %b", c, ctl, exp_ctl[c]); end
      n_assert++;
      if (bus.ramaddr !== exp_addr[c]) begin n_fail++; $display("FAIL wd_addr c%0d: got %h want %h", c, bus.ramaddr, exp_addr[c]); end
      n_assert++;
      if (bus.dload !== exp_dld[c] || bus.iload !== 32'h0) begin
        n_fail++; $display("FAIL wd_load c%0d: got iload=%h dload=%h want 0 %h", c, bus.iload, bus.dload, exp_dld[c]);
      end
    end
    idle_inputs();
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    nRST     = 1'b0;
    idle_inputs();
    test_reset();
    test_ifetch();
    test_contention();
    test_write_priority();
    test_error_retry();
    test_withdraw();
    @(negedge CLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Responder end of the cache-to-memory request interface.
- Accepts instruction-fetch requests (iREN/iaddr) from the icache and read/write requests (dREN/dWEN/daddr/dstore) from the dcache.
- Grants one request at a time, drives the single-ported RAM, and returns iwait/iload and dwait/dload.
- Sits between the caches and the RAM model, in place of the combinational memory controller.

Parameters:
- RR_EN, 1, when 1, icache/dcache arbitration alternates after each data access; when 0, the dcache always wins.

Ports:
- CLK  in  1  system clock, rising edge.
- nRST  in  1  asynchronous, active-low reset.
- iREN  in  1  icache fetch request; held until iwait is observed low.
- iaddr  in  32  fetch word address.
- iwait  out  1  0 for exactly one cycle when iload is valid; 1 otherwise.
- iload  out  32  fetched instruction.
- dREN  in  1  dcache read request.
- dWEN  in  1  dcache write request.
- daddr  in  32  data word address.
- dstore  in  32  write data.
- dwait  out  1  0 for exactly one cycle when a data access completes; 1 otherwise.
- dload  out  32  read data.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data.
- ramstate  in  2  ramstate_t from cpu_types_pkg: FREE, BUSY, ACCESS, ERROR.

Behaviour:
- Reset, asynchronous, active-low:
  - State goes to MA_IDLE and last_grant to ICACHE.
  - iwait=1, dwait=1; ramREN=0, ramWEN=0.
  - ramaddr, ramstore, iload and dload all read 0.
- States: MA_IDLE, MA_IFETCH, MA_DREAD, MA_DWRITE.
- MA_IDLE, arbitration on the current inputs; the next state is registered:
  - dWEN=1 goes to MA_DWRITE. dWEN beats dREN if both are asserted.
  - Otherwise dREN=1 goes to MA_DREAD.
  - Otherwise iREN=1 goes to MA_IFETCH.
  - Data request and iREN together:
    - RR_EN=0: the data side wins.
    - RR_EN=1: the data side wins unless last_grant==DCACHE, in which case MA_IFETCH is granted.
  - No RAM enables are asserted in MA_IDLE, so every transaction costs at least one arbitration cycle.
- MA_IFETCH:
  - Drives ramREN=1 and ramaddr=iaddr.
  - On ramstate==ACCESS:
    - iwait=0 combinationally in that same cycle.
    - iload=ramload in that same cycle.
    - Next state is MA_IDLE; last_grant<=ICACHE.
- MA_DREAD:
  - Drives ramREN=1 and ramaddr=daddr.
  - On ACCESS: dwait=0, dload=ramload, next state MA_IDLE, last_grant<=DCACHE.
- MA_DWRITE:
  - Drives ramWEN=1, ramaddr=daddr and ramstore=dstore.
  - On ACCESS: dwait=0, next state MA_IDLE, last_grant<=DCACHE.
- ramstate FREE or BUSY in a grant state: hold the state and the RAM drives; wait stays 1.
- ramstate ERROR: same as BUSY. The access is retried, no wait is dropped and no data is returned.
- Request withdrawn mid-grant:
  - Applies when the granted requester's enable drops before ACCESS (e.g. the icache PC is redirected).
  - Next state is MA_IDLE, RAM enables deassert the next cycle, and no wait pulse is issued.
  - last_grant is unchanged.
- The non-granted requester always sees wait=1. Its request stays pending and is arbitrated in the next MA_IDLE.
- Addresses and data are not latched; requesters hold them stable while their enable is high.
- iload and dload are 0 except in their completion cycle.
- Never: ramREN and ramWEN high together; both waits low in the same cycle.
- Minimum latency, request to wait low: 2 cycles with a 0-latency RAM.

Decomposition:
- Add to caches_types_pkg:
  - mem_arb_state_t, with values MA_IDLE, MA_IFETCH, MA_DREAD, MA_DWRITE.
  - arb_owner_t, with values ICACHE, DCACHE.
- Reuse ramstate_t and word_t from cpu_types_pkg.
- Single module, no sub-module. The arbitration decision is a small combinational block inside it.

Test Plan:
- Reset and idle: nRST low mid-MA_DREAD → the next sample shows iwait=dwait=1, ramREN=ramWEN=0, state MA_IDLE.
- Icache fetch: iREN=1, iaddr=0x0000_0040, RAM returns 0x2401_0005 with ACCESS after 2 BUSY cycles → ramREN=1 with ramaddr=0x40 for 3 cycles; iwait=0 and iload=0x2401_0005 for exactly 1 cycle; then MA_IDLE.
- Contention, RR_EN=1: dREN and iREN held together from reset → order is DREAD, IFETCH, DREAD, IFETCH; each wait drops once per grant.
- Write priority: dWEN=1 and dREN=1 at daddr=0x100 with dstore=0xDEAD_BEEF → ramWEN=1, ramREN=0, ramstore=0xDEAD_BEEF; dwait low once.
- ERROR retry: ramstate=ERROR for 3 cycles, then ACCESS → request held for 4 cycles; wait low only in the ACCESS cycle.
- Withdrawal: iREN drops while ramstate=BUSY → MA_IDLE next cycle, iwait never low, and a pending dREN is granted next.
